// File: rtl/rr_port_arbiter_pkg.sv
// rr_port_arbiter_pkg: shared sizes, FSM state type and one-hot decode for the port arbiter.
// Contents:
//   NREQ      number of requesters
//   SEL_W     width of a requester index / mux select
//   state_e   arbiter FSM states
//   onehot4   index -> one-hot grant/ack vector
package rr_port_arbiter_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_port_arbiter_if.sv
// rr_port_arbiter_if: requester/slave-facing signal bundle of the port arbiter.
// Signals:
//   req         in   per-requester request level, held until ack
//   mem_done    in   slave completion strobe
//   sel         out  mux select, index of current/last grantee
//   gnt         out  one-hot grant, zero outside BUSY
//   mem_valid   out  port command valid during BUSY
//   ack         out  one-cycle one-hot completion pulse
//   busy        out  high in BUSY or ACK
//   timeout_err out  sticky watchdog abort flag
//   err_id      out  requester index of the latest timeout
// Modports: master = arbiter side, slave = requesters/slave side.
interface rr_port_arbiter_if;
    import rr_port_arbiter_pkg::*;

    logic [NREQ-1:0]  req;
    logic             mem_done;
    logic [SEL_W-1:0] sel;
    logic [NREQ-1:0]  gnt;
    logic             mem_valid;
    logic [NREQ-1:0]  ack;
    logic             busy;
    logic             timeout_err;
    logic [SEL_W-1:0] err_id;

    modport master (
        input  req, mem_done,
        output sel, gnt, mem_valid, ack, busy, timeout_err, err_id
    );

    modport slave (
        output req, mem_done,
        input  sel, gnt, mem_valid, ack, busy, timeout_err, err_id
    );

endinterface

// File: rtl/rr_port_arbiter_pick4.sv
// rr_pick4: combinational rotating-priority search over four requests.
// Ports:
//   req_i   request vector
//   last_i  index granted last; the search starts one above it and wraps
//   any_o   at least one request present
//   idx_o   winning index (0 when any_o is low)
module rr_pick4
    import rr_port_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req_i,
    input  logic [SEL_W-1:0] last_i,
    output logic             any_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [SEL_W-1:0] cand;

    // Walk from farthest to nearest so the nearest set bit after last_i
    // is the final assignment and therefore wins.
    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        cand  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = last_i + SEL_W'(i);
            if (req_i[cand]) idx_o = cand;
        end
    end

endmodule

// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter: four-requester round-robin arbiter for one shared port with timeout watchdog.
// Ports:
//   clk_i   system clock, rising edge
//   rstn_i  asynchronous active-low reset
//   bus     rr_port_arbiter_if.master (req/mem_done in; sel/gnt/mem_valid/ack/busy/
//           timeout_err/err_id out, all registered)
// Parameters:
//   TIMEOUT_CYC  BUSY cycles before a forced abort; 0 disables the watchdog
//   CNT_W        watchdog counter width, must satisfy TIMEOUT_CYC < 2**CNT_W
module rr_port_arbiter
    import rr_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    rr_port_arbiter_if.master bus
);

    localparam bit               TO_EN   = TIMEOUT_CYC != 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYC - 1 : 0);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             mem_valid_q, mem_valid_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             terr_q, terr_d;
    logic [SEL_W-1:0] err_id_q, err_id_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             timeout;

    rr_pick4 u_pick (
        .req_i  (bus.req),
        .last_i (last_q),
        .any_o  (pick_any),
        .idx_o  (pick_idx)
    );

    // cnt_q counts completed BUSY cycles, so it equals TIMEOUT_CYC-1 in the
    // last permitted BUSY cycle.
    assign timeout = TO_EN && (cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        mem_valid_d = mem_valid_q;
        ack_d       = '0;
        busy_d      = busy_q;
        terr_d      = terr_q;
        err_id_d    = err_id_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = BUSY;
                    sel_d       = pick_idx;
                    gnt_d       = onehot4(pick_idx);
                    mem_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.mem_done || timeout) begin
                    state_d     = ACK;
                    last_d      = sel_q;
                    gnt_d       = '0;
                    mem_valid_d = 1'b0;
                    ack_d       = onehot4(sel_q);
                    cnt_d       = '0;
                    // A completion arriving together with the timeout is a success.
                    if (!bus.mem_done) begin
                        terr_d   = 1'b1;
                        err_id_d = sel_q;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                mem_valid_d = 1'b0;
                busy_d      = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            gnt_q       <= '0;
            mem_valid_q <= 1'b0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
            err_id_q    <= '0;
            last_q      <= SEL_W'(NREQ - 1);
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            mem_valid_q <= mem_valid_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            terr_q      <= terr_d;
            err_id_q    <= err_id_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.gnt         = gnt_q;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.ack         = ack_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;
    assign bus.err_id      = err_id_q;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// tb_rr_port_arbiter: directed self-checking bench for rr_port_arbiter.
// Two instances share req/mem_done/reset: u8 (TIMEOUT_CYC=8) and u4 (TIMEOUT_CYC=4).
module tb_rr_port_arbiter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rr_port_arbiter_if a ();
    rr_port_arbiter_if b ();

    assign b.req      = a.req;
    assign b.mem_done = a.mem_done;

    rr_port_arbiter #(.TIMEOUT_CYC(8), .CNT_W(8)) u8 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (a)
    );

    rr_port_arbiter #(.TIMEOUT_CYC(4), .CNT_W(8)) u4 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (b)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // One transaction on u8: req=r, expected winner g, mem_done in BUSY cycle n.
    task automatic txn(input logic [3:0] r, input int g, input int n);
        logic [3:0] oh;
        oh = 4'(1 << g);
        a.req = r;
        tick();
        for (int c = 1; c <= n; c++) begin
            chk("busy_gnt", 8'(a.gnt), 8'(oh));
            chk("busy_sel", 8'(a.sel), 8'(g));
            chk("busy_valid", 8'(a.mem_valid), 8'd1);
            if (c == n) a.mem_done = 1'b1;
            tick();
        end
        chk("ack_ack", 8'(a.ack), 8'(oh));
        chk("ack_gnt", 8'(a.gnt), 8'd0);
        chk("ack_busy", 8'(a.busy), 8'd1);
        a.mem_done = 1'b0;
        a.req = 4'b0000;
        tick();
        chk("idle_ack", 8'(a.ack), 8'd0);
        chk("idle_busy", 8'(a.busy), 8'd0);
        chk("idle_sel", 8'(a.sel), 8'(g));
    endtask

    initial begin
        int cyc;
        a.req = 4'b1111;
        a.mem_done = 1'b1;
        rstn = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 8'(a.gnt), 8'd0);
        chk("rst_ack", 8'(a.ack), 8'd0);
        chk("rst_sel", 8'(a.sel), 8'd0);
        chk("rst_valid", 8'(a.mem_valid), 8'd0);
        chk("rst_busy", 8'(a.busy), 8'd0);
        chk("rst_terr", 8'(a.timeout_err), 8'd0);
        chk("rst_errid", 8'(a.err_id), 8'd0);
        a.req = 4'b0000;
        a.mem_done = 1'b0;
        rstn = 1'b1;
        tick();

        // single request, done in 3rd BUSY cycle
        txn(4'b0001, 0, 3);
        tick();
        chk("idle_hold_sel", 8'(a.sel), 8'd0);

        // full contention from reset: 0,1,2,3,0 with 3-cycle spacing
        do_reset();
        txn(4'b1111, 0, 1);
        txn(4'b1111, 1, 1);
        txn(4'b1111, 2, 1);
        txn(4'b1111, 3, 1);
        txn(4'b1111, 0, 1);

        // rotation skip: last_grant=1, req=0011 -> 0
        txn(4'b0010, 1, 1);
        txn(4'b0011, 0, 1);

        // timeout on u8 for requester 2
        a.req = 4'b0100;
        tick();
        cyc = 0;
        while (a.gnt != 4'b0000 && cyc < 20) begin
            cyc++;
            tick();
        end
        chk("to_cycles", 8'(cyc), 8'd8);
        chk("to_ack", 8'(a.ack), 8'b0100);
        chk("to_terr", 8'(a.timeout_err), 8'd1);
        chk("to_errid", 8'(a.err_id), 8'd2);
        a.req = 4'b0000;
        tick();
        txn(4'b0001, 0, 1);
        chk("to_sticky", 8'(a.timeout_err), 8'd1);
        chk("to_errid_keep", 8'(a.err_id), 8'd2);

        // asynchronous reset in the middle of BUSY
        a.req = 4'b0001;
        tick();
        chk("pre_rst_gnt", 8'(a.gnt), 8'b0001);
        #2 rstn = 1'b0;
        #1;
        chk("arst_gnt", 8'(a.gnt), 8'd0);
        chk("arst_valid", 8'(a.mem_valid), 8'd0);
        chk("arst_busy", 8'(a.busy), 8'd0);
        chk("arst_ack", 8'(a.ack), 8'd0);
        chk("arst_terr", 8'(a.timeout_err), 8'd0);
        chk("arst_errid", 8'(a.err_id), 8'd0);
        a.req = 4'b0000;
        tick();
        rstn = 1'b1;
        tick();
        chk("arst_no_ack", 8'(a.ack), 8'd0);

        // done/timeout race on u4: done in 4th BUSY cycle
        a.req = 4'b0001;
        tick();
        for (int c = 1; c <= 4; c++) begin
            chk("race_gnt", 8'(b.gnt), 8'b0001);
            if (c == 4) a.mem_done = 1'b1;
            tick();
        end
        chk("race_ack", 8'(b.ack), 8'b0001);
        chk("race_terr", 8'(b.timeout_err), 8'd0);
        a.mem_done = 1'b0;
        a.req = 4'b0000;
        tick();
        chk("race_idle_busy", 8'(b.busy), 8'd0);

        // stray mem_done in IDLE
        a.mem_done = 1'b1;
        tick();
        tick();
        chk("stray_busy", 8'(b.busy), 8'd0);
        chk("stray_gnt", 8'(b.gnt), 8'd0);
        chk("stray_ack", 8'(b.ack), 8'd0);
        chk("stray_terr", 8'(b.timeout_err), 8'd0);
        a.mem_done = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
